// File: rtl/adc_responder.sv
// adc_responder: device end of the convst/sck/sdi/sdo ADC link.
// A falling edge on convst latches sample_in and starts a conversion that lasts
// CONV_CYCLES clocks. The sample then shifts out MSB-first on sdo, advancing on
// each sck fall. The first CFG_BITS sdi bits, taken on sck rises, form cfg_word.
// Raising convst before the frame completes aborts the frame.
//
// Optional build macro: ADC_RESPONDER_SYNC_EN. When defined, convst, sck and sdi
// each pass through a 2-flop synchroniser, which adds 2 cycles to every
// input-referenced latency.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   convst, sck, sdi      strobe, serial clock and config data from the initiator
//   sample_in             value reported for the next conversion
//   sdo                   serial sample data, MSB first (registered)
//   busy                  high while converting
//   sample_taken          1-cycle pulse when sample_in is latched
//   cfg_word, cfg_valid   last complete config word and its 1-cycle update pulse
//   frame_done            1-cycle pulse after the last data bit
module adc_responder #(
  parameter int unsigned DATA_BITS   = 12,
  parameter int unsigned CFG_BITS    = 6,
  parameter int unsigned CONV_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 convst,
  input  logic                 sck,
  input  logic                 sdi,
  output logic                 sdo,
  input  logic [DATA_BITS-1:0] sample_in,
  output logic                 busy,
  output logic                 sample_taken,
  output logic [CFG_BITS-1:0]  cfg_word,
  output logic                 cfg_valid,
  output logic                 frame_done
);

  localparam int unsigned CNT_W  = $clog2(CONV_CYCLES + 1);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned RISE_W = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_SHIFT,
    ST_DONE
  } state_e;

  logic convst_s, sck_s, sdi_s;

`ifdef ADC_RESPONDER_SYNC_EN
  // Two-flop synchronisers; reset values match the idle levels of the link.
  logic [1:0] convst_sync_q, sck_sync_q, sdi_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      convst_sync_q <= 2'b11;
      sck_sync_q    <= 2'b00;
      sdi_sync_q    <= 2'b00;
    end else begin
      convst_sync_q <= {convst_sync_q[0], convst};
      sck_sync_q    <= {sck_sync_q[0], sck};
      sdi_sync_q    <= {sdi_sync_q[0], sdi};
    end
  end

  assign convst_s = convst_sync_q[1];
  assign sck_s    = sck_sync_q[1];
  assign sdi_s    = sdi_sync_q[1];
`else
  assign convst_s = convst;
  assign sck_s    = sck;
  assign sdi_s    = sdi;
`endif

  // Previous-value registers for edge detection.
  logic convst_prev_q, sck_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      convst_prev_q <= 1'b1;
      sck_prev_q    <= 1'b0;
    end else begin
      convst_prev_q <= convst_s;
      sck_prev_q    <= sck_s;
    end
  end

  logic conv_fall, sck_rise, sck_fall;
  assign conv_fall = convst_prev_q & ~convst_s;
  assign sck_rise  = ~sck_prev_q & sck_s;
  assign sck_fall  = sck_prev_q & ~sck_s;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [RISE_W-1:0]     rise_cnt_q, rise_cnt_d;
  logic [CFG_BITS-1:0]   cfg_sr_q, cfg_sr_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic                  sample_taken_q, sample_taken_d;
  logic [CFG_BITS-1:0]   cfg_word_q, cfg_word_d;
  logic                  cfg_valid_q, cfg_valid_d;
  logic                  frame_done_q, frame_done_d;

  logic [DATA_BITS-1:0]  shift_next;
  logic [CFG_BITS-1:0]   cfg_next;

  assign shift_next = shift_q << 1;
  assign cfg_next   = CFG_BITS'({cfg_sr_q, sdi_s});

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      rise_cnt_q     <= '0;
      cfg_sr_q       <= '0;
      sdo_q          <= 1'b0;
      busy_q         <= 1'b0;
      sample_taken_q <= 1'b0;
      cfg_word_q     <= '0;
      cfg_valid_q    <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      rise_cnt_q     <= rise_cnt_d;
      cfg_sr_q       <= cfg_sr_d;
      sdo_q          <= sdo_d;
      busy_q         <= busy_d;
      sample_taken_q <= sample_taken_d;
      cfg_word_q     <= cfg_word_d;
      cfg_valid_q    <= cfg_valid_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    rise_cnt_d     = rise_cnt_q;
    cfg_sr_d       = cfg_sr_q;
    sdo_d          = sdo_q;
    busy_d         = busy_q;
    sample_taken_d = 1'b0;
    cfg_word_d     = cfg_word_q;
    cfg_valid_d    = 1'b0;
    frame_done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (conv_fall) begin
          shift_d        = sample_in;
          sample_taken_d = 1'b1;
          busy_d         = 1'b1;
          cnt_d          = CNT_W'(CONV_CYCLES);
          state_d        = ST_CONV;
        end
      end

      ST_CONV: begin
        if (convst_s) begin
          busy_d  = 1'b0;
          sdo_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          // Counter was loaded with CONV_CYCLES, so busy spans exactly that many cycles.
          busy_d     = 1'b0;
          sdo_d      = shift_q[DATA_BITS-1];
          bit_cnt_d  = '0;
          rise_cnt_d = '0;
          cfg_sr_d   = '0;
          state_d    = ST_SHIFT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        // Abort takes priority over any sck edge in the same cycle.
        if (convst_s) begin
          sdo_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          if (rise_cnt_q < RISE_W'(CFG_BITS)) begin
            cfg_sr_d   = cfg_next;
            rise_cnt_d = rise_cnt_q + RISE_W'(1);
            if (rise_cnt_q == RISE_W'(CFG_BITS - 1)) begin
              cfg_word_d  = cfg_next;
              cfg_valid_d = 1'b1;
            end
          end
        end else if (sck_fall) begin
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            sdo_d        = 1'b0;
            frame_done_d = 1'b1;
            state_d      = ST_DONE;
          end else begin
            shift_d   = shift_next;
            sdo_d     = shift_next[DATA_BITS-1];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      ST_DONE: begin
        sdo_d = 1'b0;
        if (convst_s) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign sdo          = sdo_q;
  assign busy         = busy_q;
  assign sample_taken = sample_taken_q;
  assign cfg_word     = cfg_word_q;
  assign cfg_valid    = cfg_valid_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_adc_responder.sv
// Bench for adc_responder: a randomized initiator drives frames, and a
// transaction-level model predicts each frame's results.
module tb_adc_responder;

  localparam int unsigned DATA_BITS   = 12;
  localparam int unsigned CFG_BITS    = 6;
  localparam int unsigned CONV_CYCLES = 2;
`ifdef ADC_RESPONDER_SYNC_EN
  localparam int SYNC_LAT = 2;
  localparam int MIN_HALF = 2;
`else
  localparam int SYNC_LAT = 0;
  localparam int MIN_HALF = 1;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 convst;
  logic                 sck;
  logic                 sdi;
  logic                 sdo;
  logic [DATA_BITS-1:0] sample_in;
  logic                 busy;
  logic                 sample_taken;
  logic [CFG_BITS-1:0]  cfg_word;
  logic                 cfg_valid;
  logic                 frame_done;

  adc_responder #(
    .DATA_BITS  (DATA_BITS),
    .CFG_BITS   (CFG_BITS),
    .CONV_CYCLES(CONV_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .convst      (convst),
    .sck         (sck),
    .sdi         (sdi),
    .sdo         (sdo),
    .sample_in   (sample_in),
    .busy        (busy),
    .sample_taken(sample_taken),
    .cfg_word    (cfg_word),
    .cfg_valid   (cfg_valid),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters, sampled on the falling edge.
  int taken_n = 0, valid_n = 0, done_n = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (sample_taken) taken_n = taken_n + 1;
      if (cfg_valid)    valid_n = valid_n + 1;
      if (frame_done)   done_n  = done_n + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [CFG_BITS-1:0] exp_cfg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance n clocks; inputs are driven and outputs read 1 unit after the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({sdo, busy, sample_taken, cfg_valid, frame_done, cfg_word});
  endfunction

  // One initiator frame. abort_at < 0 runs to completion; otherwise convst is
  // raised after abort_at sck falls, optionally together with an sck rise.
  task automatic run_frame(input logic [11:0] smp, input logic [5:0] cbits,
                           input int abort_at, input bit abort_rise,
                           input bit change_smp, input int hi, input int lo);
    logic [11:0] rd;
    int c0, t0, v0, d0;
    bit ok;
    convst = 1'b1; sck = 1'b0; sdi = 1'b0;
    step(2 + SYNC_LAT);
    t0 = taken_n; v0 = valid_n; d0 = done_n;
    sample_in = smp;
    convst = 1'b0;
    c0 = cyc;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (sample_taken) begin ok = 1'b1; break; end
    end
    check("taken_lat", ok ? 32'(cyc - c0) : 32'hFFFF_FFFF, 32'(1 + SYNC_LAT));
    check("busy_at_take", 32'(busy), 32'd1);
    if (change_smp) sample_in = ~smp;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!busy) begin ok = 1'b1; break; end
      step(1);
    end
    check("busy_lat", ok ? 32'(cyc - c0) : 32'hFFFF_FFFF, 32'(1 + CONV_CYCLES + SYNC_LAT));
    check("sdo_msb", 32'(sdo), 32'(smp[11]));
    rd = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == abort_at) break;
      sck = 1'b1;
      sdi = (i < 6) ? cbits[5 - i] : 1'($urandom_range(0, 1));
      step(hi);
      rd[11 - i] = sdo;
      sck = 1'b0;
      step(lo);
    end
    if (abort_at >= 0) begin
      convst = 1'b1;
      if (abort_rise) begin sck = 1'b1; sdi = 1'b1; end
      step(1 + SYNC_LAT);
      check("abort_sdo", 32'(sdo), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      step(4);
      if (abort_at >= 6) exp_cfg = cbits;
      check("abort_done_cnt", 32'(done_n - d0), 32'd0);
      check("abort_valid_cnt", 32'(valid_n - v0), (abort_at >= 6) ? 32'd1 : 32'd0);
      check("abort_cfg", 32'(cfg_word), 32'(exp_cfg));
      if (abort_at > 0)
        check("abort_bits", 32'(rd) >> (12 - abort_at), 32'(smp) >> (12 - abort_at));
    end else begin
      step(SYNC_LAT + 2);
      exp_cfg = cbits;
      check("end_sdo", 32'(sdo), 32'd0);
      check("frame_bits", 32'(rd), 32'(smp));
      check("cfg_word", 32'(cfg_word), 32'(exp_cfg));
      check("valid_cnt", 32'(valid_n - v0), 32'd1);
      check("done_cnt", 32'(done_n - d0), 32'd1);
      // sck activity after the frame must not disturb anything.
      sck = 1'b1; step(hi);
      sck = 1'b0; step(lo + SYNC_LAT + 1);
      check("done_sdo", 32'(sdo), 32'd0);
      check("done_cnt_hold", 32'(done_n - d0), 32'd1);
    end
    check("taken_cnt", 32'(taken_n - t0), 32'd1);
    convst = 1'b1; sck = 1'b0; sdi = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] r_smp;
    logic [5:0]  r_cfg;
    int r_ab, r_hi, r_lo;
    bit r_ar;
    bit ok;

    reset = 1'b1; convst = 1'b1; sck = 1'b0; sdi = 1'b0;
    sample_in = 12'hA5C; exp_cfg = '0;
    step(3);
    check("reset_outs", all_outs(), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_outs", all_outs(), 32'd0);
    end

    // Directed frames.
    run_frame(12'hA5C, 6'b101101, -1, 1'b0, 1'b0, MIN_HALF, MIN_HALF);
    run_frame(12'hFFF, 6'b010010, 5, 1'b0, 1'b0, MIN_HALF, MIN_HALF);
    run_frame(12'hFFF, 6'b000111, 5, 1'b1, 1'b0, MIN_HALF + 1, MIN_HALF);
    run_frame(12'h123, 6'b110011, -1, 1'b0, 1'b1, MIN_HALF, MIN_HALF + 1);

    // Randomized frames.
    repeat (40) begin
      r_smp = 12'($urandom);
      r_cfg = 6'($urandom);
      r_ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : -1;
      r_ar  = 1'($urandom_range(0, 1));
      r_hi  = int'($urandom_range(MIN_HALF, 3));
      r_lo  = int'($urandom_range(MIN_HALF, 3));
      run_frame(r_smp, r_cfg, r_ab, r_ar, 1'($urandom_range(0, 1)), r_hi, r_lo);
    end

    // Reset in the middle of a frame clears everything, including cfg_word.
    step(2 + SYNC_LAT);
    sample_in = 12'($urandom);
    convst = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (sample_taken) ok = 1'b1;
      if (ok && !busy) break;
    end
    for (int i = 0; i < 7; i++) begin
      sck = 1'b1; sdi = 1'b1; step(MIN_HALF);
      sck = 1'b0; step(MIN_HALF);
    end
    step(SYNC_LAT + 1);
    check("pre_reset_cfg", 32'(cfg_word), 32'h3F);
    #2 reset = 1'b1;
    #1 check("async_reset_outs", all_outs(), 32'd0);
    exp_cfg = '0;
    convst = 1'b1; sck = 1'b0; sdi = 1'b0;
    step(2);
    reset = 1'b0;
    step(3);
    check("post_reset_outs", all_outs(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_responder.md
# adc_responder

Serial responder for the ADC conversion interface: the device-side end of the convst/sck/sdi/sdo link driven by `adc_interface`. Latches a 12-bit sample when the initiator starts a conversion and models conversion busy time. Shifts the sample out MSB-first on `sdo` and captures the configuration word the initiator sends on `sdi`. Used as an ADC stand-in for bench and board loopback, and as the front end of a sensor emulator feeding recorded bike-sensor data.

## Interface
- `DATA_BITS`, 12: sample width shifted out on `sdo`.
- `CFG_BITS`, 6: configuration bits captured from `sdi` per frame.
- `CONV_CYCLES`, 2: `clk` cycles of conversion time; must be ≥1.

- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `convst` input 1: conversion start/frame strobe from initiator; idles high.
- `sck` input 1: serial clock from initiator.
- `sdi` input 1: serial config data from initiator.
- `sdo` output 1: serial sample data, MSB first; registered.
- `sample_in` input DATA_BITS: value to report; sampled at conversion start.
- `busy` output 1: high while converting.
- `sample_taken` output 1: one-cycle pulse when `sample_in` is latched.
- `cfg_word` output CFG_BITS: last complete configuration word, first bit received in MSB.
- `cfg_valid` output 1: one-cycle pulse when `cfg_word` updates.
- `frame_done` output 1: one-cycle pulse after all DATA_BITS bits are shifted.

## Operation
- Reset values:
  - `sdo`, `busy`, `sample_taken`, `cfg_valid`, `frame_done`: 0.
  - `cfg_word`: 0.
  - State: IDLE.
- Edge detection uses registered previous copies of `convst` and `sck`, both reset to 1 and 0 respectively:
  - conv_fall = prev=1 and now=0.
  - sck_rise and sck_fall are defined the same way on `sck`.
- States:
  - IDLE:
    - On conv_fall: latch `sample_in` into shift register, pulse `sample_taken`, set `busy`=1, load conversion counter, go to CONV.
  - CONV:
    - Counter counts down CONV_CYCLES.
    - At terminal count: `busy`=0, `sdo`=shift MSB, bit count=0, go to SHIFT.
    - `sck` and `sdi` edges are ignored in CONV.
  - SHIFT:
    - sck_rise: while rise count < CFG_BITS, shift `sdi` into cfg shift register. On the CFG_BITS-th rise, `cfg_word` updates and `cfg_valid` pulses in the same update.
    - sck_fall: shift the sample left; `sdo` = next bit; bit count +1.
    - After the DATA_BITS-th fall: `sdo`=0, pulse `frame_done`, go to DONE.
  - DONE:
    - `sdo` held 0; further `sck` edges are ignored.
    - `convst` high returns to IDLE.
- Abort: `convst` high in CONV or SHIFT:
  - Return to IDLE next cycle with `sdo`=0 and `busy`=0.
  - No `frame_done`; no `cfg_valid` unless already pulsed.
  - Partial cfg bits are discarded; `cfg_word` keeps its previous value.
- conv_fall is only acted on in IDLE.
- Simultaneous abort and sck edge: abort wins; the edge is ignored.
- Reset mid-frame: immediate return to reset values; `cfg_word` is cleared.

## Timing
- Without sync (see Configuration): edges are detected in the cycle the input changes; the registered effect is visible the following cycle.
  - conv_fall in cycle N: `sample_taken` and `busy` high in N+1.
  - `busy` falls and `sdo`=MSB in N+1+CONV_CYCLES.
  - sck_fall in cycle M: new `sdo` bit in M+1.
- With sync: add 2 cycles to every input-referenced latency above.
- Supports `sck` toggling every `clk` cycle without sync. With sync, `sck` high and low phases must each be ≥2 `clk` cycles.
- Initiator samples `sdo` while `sck` is high. `sdo` is stable from one cycle after sck_fall until the next sck_fall.

## Configuration
- `ADC_RESPONDER_SYNC_EN` defined:
  - `convst`, `sck` and `sdi` each pass through a 2-flop synchroniser, reset to 1, 0 and 0 respectively, before edge detection and use.
  - For an asynchronous or board-level initiator.
- Undefined:
  - Inputs are used directly; only the previous-value registers exist.
  - Requires an initiator on the same `clk`.

## Test plan
- Reset with `sample_in`=12'hA5C, no stimulus:
  - All outputs are 0 and stay 0.
  - State stays IDLE for 20 cycles.
- Full frame, `sample_in`=12'hA5C:
  - Stimulus: `convst` falls; after `busy` drops, 12 `sck` periods; `sdi` pattern 1,0,1,1,0,1.
  - `sdo` bits read on `sck` high: 1010_0101_1100.
  - `cfg_word`=6'b101101 with one `cfg_valid` pulse.
  - One `frame_done` pulse, then `sdo`=0.
- Latency check, no sync, CONV_CYCLES=2:
  - `convst` falls in cycle 10 → `sample_taken` high in 11 only.
  - `busy` high in 11–12, low in 13.
  - `sdo`=MSB in 13.
- Abort, `sample_in`=12'hFFF:
  - Stimulus: `convst` goes high after 5 `sck` falls.
  - `sdo`=0 next cycle; no `frame_done`; no `cfg_valid`.
  - `cfg_word` unchanged from the previous frame.
- `sample_in` change:
  - `sample_in` changes from 12'h123 to 12'h456 one cycle after `convst` falls.
  - Shifted data is 12'h123.
- Sync build with `ADC_RESPONDER_SYNC_EN` defined, `sck` = clk/4:
  - Same frame as the full-frame scenario yields identical bits.
  - Every latency is 2 cycles longer.
